fsm_packet_assembler: RTL and testbench
=======================================

# fsm_packet_assembler

Deparser-side counterpart of the scheduler's packet dispatcher. It recombines the analysed header beats (up to COUNT_META_DATA_MAX, from the match/deparser header path) with the remaining payload beats into one AXI-Stream packet per frame. It applies a per-packet forward/drop verdict; dropped packets have both segments consumed with nothing emitted. It sits between the data_processing header/payload paths and the egress AXIS interface.

## Interface
Parameters:
- AXIS_DATA_WIDTH, 64, stream data width
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width
- COUNT_META_DATA_MAX, 5, maximum header beats per packet
- COUNTER_WIDTH, $clog2(COUNT_META_DATA_MAX+1), header beat counter width
- STATE_WIDTH, 3, state encoding width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset (one clock; reset is asynchronous and active-low)
- enable_dp  in  1  1 = assemble header+payload; 0 = bypass (payload stream only)
- rst_counters  in  1  synchronous clear of statistics counters and error flag
- s_verdict_valid / s_verdict_ready  in/out  1/1  per-packet verdict handshake
- s_verdict_drop  in  1  1 = drop the packet
- s_verdict_short  in  1  1 = packet ends within header, no payload segment
- s_axis_hdr_tdata / tkeep / tlast / tvalid / tready  in,in,in,in,out  DATA/KEEP/1/1/1  header beats; tlast = last header beat
- s_axis_pl_tdata / tkeep / tlast / tvalid / tready  in,in,in,in,out  DATA/KEEP/1/1/1  payload beats; tlast = end of packet
- m_axis_tdata / tkeep / tlast / tvalid / tready  out,out,out,out,in  DATA/KEEP/1/1/1  assembled output
- reg_pkt_counter  out  32  packets emitted
- reg_drop_counter  out  32  packets dropped
- err_hdr_len  out  1  sticky flag: header exceeded COUNT_META_DATA_MAX beats
- state  out  STATE_WIDTH  current state
- count  out  COUNTER_WIDTH  header beat index

## Operation
- States: IDLE=0, SEND_HDR=1, SEND_PAYLOAD=2, DROP_HDR=3, DROP_PAYLOAD=4. Any other encoding goes to IDLE.
- IDLE, with enable_dp=1: s_verdict_ready = s_verdict_valid & s_axis_hdr_tvalid. On accept, latch drop and short.
  - drop=0 → SEND_HDR.
  - drop=1 → DROP_HDR, and reg_drop_counter += 1.
- IDLE, with enable_dp=0: if s_axis_pl_tvalid → SEND_PAYLOAD. No verdict is consumed and the header stream is untouched.
- enable_dp is sampled only in IDLE. Changing it mid-packet has no effect until the packet ends.
- SEND_HDR: m_axis_tdata/tkeep = header beat.
  - m_axis_tvalid = hdr_tvalid; hdr_tready = m_axis_tready.
  - m_axis_tlast = hdr_tlast & short.
  - On a handshake with hdr_tlast: short → IDLE with reg_pkt_counter += 1; otherwise → SEND_PAYLOAD.
- SEND_PAYLOAD: pure passthrough of the payload stream. On a handshake with tlast → IDLE and reg_pkt_counter += 1.
- DROP_HDR: hdr_tready=1 and m_axis_tvalid=0. On hdr_tlast: short → IDLE; otherwise → DROP_PAYLOAD.
- DROP_PAYLOAD: pl_tready=1. On pl_tlast → IDLE.
- count: cleared in IDLE; increments on each header-beat handshake (send or drop).
- Header overflow: a header handshake with count==COUNT_META_DATA_MAX-1 and hdr_tlast=0 sets err_hdr_len. count holds and beats continue to pass until hdr_tlast.
- Counters are 32-bit and wrap modulo 2^32. rst_counters has priority over a same-cycle increment and also clears err_hdr_len.
- In every state, tready of the streams not listed is 0, and s_verdict_ready=0 outside IDLE.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, count=0, latched drop/short=0, counters=0, err_hdr_len=0.
  - In reset, all m_axis_* and s_*_tready outputs are 0. m_axis_tdata/tkeep are don't-care.
- Reset asserted mid-packet returns to IDLE immediately. Partial beats are abandoned; upstream realignment is the sender's responsibility.
- All output handshake signals are combinational from state and inputs. There is no data register, so the datapath latency is 0 cycles.
- Verdict accept costs 1 IDLE cycle per packet. The first header beat can transfer on the cycle after the accept.
- Bypass mode also costs 1 IDLE cycle before the first payload beat.
- Back-to-back packets: tlast cycle → IDLE (1 cycle) → next packet.
- Backpressure: m_axis_tready=0 holds the state and count and stalls the source stream. No beats are lost or duplicated.

## Test plan
- Forward, 5 header + 3 payload beats, drop=0, short=0, tready=1 → 8 output beats, tlast only on payload beat 3, reg_pkt_counter=1, 1 idle cycle before beat 1.
- Short packet, 2 header beats, short=1 → 2 output beats with tlast on beat 2, s_axis_pl_tready stays 0, state returns to IDLE the cycle after.
- Drop, 5 header + 4 payload beats, drop=1 → m_axis_tvalid never 1, all 9 beats consumed, reg_drop_counter=1, reg_pkt_counter unchanged.
- enable_dp=0 with a 6-beat payload packet and a pending verdict → 6 beats forwarded, s_verdict_ready and hdr_tready stay 0.
- Random m_axis_tready (50%) over 100 forwarded packets → output beat sequence equals concatenated input; rst_counters pulse mid-run zeroes both counters that cycle.
- 6 header beats with tlast on beat 6 → err_hdr_len=1, count holds at 4, all 6 beats forwarded; rst_n low mid-payload → IDLE and all outputs 0 within the same cycle.

Source files
------------

// File: rtl/fsm_packet_assembler.sv
// Recombines analysed header beats with the remaining payload beats into one AXI-Stream packet,
// applying a per-packet forward/drop verdict. Handshakes are combinational; no data register.
module fsm_packet_assembler #(
  parameter int unsigned AXIS_DATA_WIDTH     = 64,
  parameter int unsigned AXIS_KEEP_WIDTH     = AXIS_DATA_WIDTH / 8,
  parameter int unsigned COUNT_META_DATA_MAX = 5,
  parameter int unsigned COUNTER_WIDTH       = $clog2(COUNT_META_DATA_MAX + 1),
  parameter int unsigned STATE_WIDTH         = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_enable_dp,
  input  logic                       i_rst_counters,
  input  logic                       i_s_verdict_valid,
  output logic                       o_s_verdict_ready,
  input  logic                       i_s_verdict_drop,
  input  logic                       i_s_verdict_short,
  input  logic [AXIS_DATA_WIDTH-1:0] i_s_axis_hdr_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] i_s_axis_hdr_tkeep,
  input  logic                       i_s_axis_hdr_tlast,
  input  logic                       i_s_axis_hdr_tvalid,
  output logic                       o_s_axis_hdr_tready,
  input  logic [AXIS_DATA_WIDTH-1:0] i_s_axis_pl_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] i_s_axis_pl_tkeep,
  input  logic                       i_s_axis_pl_tlast,
  input  logic                       i_s_axis_pl_tvalid,
  output logic                       o_s_axis_pl_tready,
  output logic [AXIS_DATA_WIDTH-1:0] o_m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] o_m_axis_tkeep,
  output logic                       o_m_axis_tlast,
  output logic                       o_m_axis_tvalid,
  input  logic                       i_m_axis_tready,
  output logic [31:0]                o_reg_pkt_counter,
  output logic [31:0]                o_reg_drop_counter,
  output logic                       o_err_hdr_len,
  output logic [STATE_WIDTH-1:0]     o_state,
  output logic [COUNTER_WIDTH-1:0]   o_count
);

  typedef enum logic [STATE_WIDTH-1:0] {
    StIdle        = STATE_WIDTH'(0),
    StSendHdr     = STATE_WIDTH'(1),
    StSendPayload = STATE_WIDTH'(2),
    StDropHdr     = STATE_WIDTH'(3),
    StDropPayload = STATE_WIDTH'(4)
  } state_e;

  localparam logic [COUNTER_WIDTH-1:0] LastIdx = COUNTER_WIDTH'(COUNT_META_DATA_MAX - 1);

  state_e                   r_state;
  logic [COUNTER_WIDTH-1:0] r_count;
  logic                     r_drop;
  logic                     r_short;
  logic [31:0]              r_pkt_cnt;
  logic [31:0]              r_drop_cnt;
  logic                     r_err;

  logic w_hdr_hs, w_pl_hs, w_v_hs, w_pkt_done, w_drop_acc, w_hdr_overflow;

  always_comb begin
    o_s_verdict_ready   = 1'b0;
    o_s_axis_hdr_tready = 1'b0;
    o_s_axis_pl_tready  = 1'b0;
    o_m_axis_tvalid     = 1'b0;
    o_m_axis_tlast      = 1'b0;
    o_m_axis_tdata      = '0;
    o_m_axis_tkeep      = '0;
    case (r_state)
      // Gated by rst_n so nothing is accepted while reset is held.
      StIdle: o_s_verdict_ready = rst_n & i_enable_dp & i_s_verdict_valid & i_s_axis_hdr_tvalid;
      StSendHdr: begin
        o_m_axis_tdata      = i_s_axis_hdr_tdata;
        o_m_axis_tkeep      = i_s_axis_hdr_tkeep;
        o_m_axis_tvalid     = i_s_axis_hdr_tvalid;
        o_m_axis_tlast      = i_s_axis_hdr_tlast & r_short;
        o_s_axis_hdr_tready = i_m_axis_tready;
      end
      StSendPayload: begin
        o_m_axis_tdata     = i_s_axis_pl_tdata;
        o_m_axis_tkeep     = i_s_axis_pl_tkeep;
        o_m_axis_tvalid    = i_s_axis_pl_tvalid;
        o_m_axis_tlast     = i_s_axis_pl_tlast;
        o_s_axis_pl_tready = i_m_axis_tready;
      end
      StDropHdr:     o_s_axis_hdr_tready = 1'b1;
      StDropPayload: o_s_axis_pl_tready  = 1'b1;
      default: ;
    endcase
  end

  assign w_hdr_hs       = i_s_axis_hdr_tvalid & o_s_axis_hdr_tready;
  assign w_pl_hs        = i_s_axis_pl_tvalid & o_s_axis_pl_tready;
  assign w_v_hs         = i_s_verdict_valid & o_s_verdict_ready;
  assign w_drop_acc     = w_v_hs & i_s_verdict_drop;
  assign w_pkt_done     = ((r_state == StSendHdr) & w_hdr_hs & i_s_axis_hdr_tlast & r_short) |
                          ((r_state == StSendPayload) & w_pl_hs & i_s_axis_pl_tlast);
  assign w_hdr_overflow = w_hdr_hs & ~i_s_axis_hdr_tlast & (r_count == LastIdx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_count    <= '0;
      r_drop     <= 1'b0;
      r_short    <= 1'b0;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_count <= '0;
          if (i_enable_dp) begin
            if (w_v_hs) begin
              r_drop  <= i_s_verdict_drop;
              r_short <= i_s_verdict_short;
              r_state <= i_s_verdict_drop ? StDropHdr : StSendHdr;
            end
          end else if (i_s_axis_pl_tvalid) begin
            r_state <= StSendPayload;
          end
        end
        StSendHdr:
          if (w_hdr_hs && i_s_axis_hdr_tlast) r_state <= r_short ? StIdle : StSendPayload;
        StSendPayload:
          if (w_pl_hs && i_s_axis_pl_tlast) r_state <= StIdle;
        StDropHdr:
          if (w_hdr_hs && i_s_axis_hdr_tlast) r_state <= r_short ? StIdle : StDropPayload;
        StDropPayload:
          if (w_pl_hs && i_s_axis_pl_tlast) r_state <= StIdle;
        default: r_state <= StIdle;
      endcase

      // Saturates at the last legal index; oversize headers keep flowing until tlast.
      if (w_hdr_hs && r_count != LastIdx) r_count <= r_count + COUNTER_WIDTH'(1);
      if (w_hdr_overflow) r_err <= 1'b1;

      if (i_rst_counters) begin
        r_pkt_cnt  <= '0;
        r_drop_cnt <= '0;
        r_err      <= 1'b0;
      end else begin
        if (w_pkt_done) r_pkt_cnt <= r_pkt_cnt + 32'd1;
        if (w_drop_acc) r_drop_cnt <= r_drop_cnt + 32'd1;
      end
    end
  end

  assign o_reg_pkt_counter  = r_pkt_cnt;
  assign o_reg_drop_counter = r_drop_cnt;
  assign o_err_hdr_len      = r_err;
  assign o_state            = r_state;
  assign o_count            = r_count;

endmodule

// File: tb/tb_fsm_packet_assembler.sv
// Randomized bench for fsm_packet_assembler: packets are described as beat lists and the
// expected egress stream and counters are derived from the forward/drop/short/bypass rules.
module tb_fsm_packet_assembler;
  localparam int DW = 64;
  localparam int KW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          enable_dp = 1'b1, rst_counters = 1'b0;
  logic          v_valid = 1'b0, v_ready, v_drop = 1'b0, v_short = 1'b0;
  logic [DW-1:0] hdr_tdata = '0, pl_tdata = '0, m_tdata;
  logic [KW-1:0] hdr_tkeep = '0, pl_tkeep = '0, m_tkeep;
  logic          hdr_tlast = 1'b0, hdr_tvalid = 1'b0, hdr_tready;
  logic          pl_tlast = 1'b0, pl_tvalid = 1'b0, pl_tready;
  logic          m_tlast, m_tvalid, m_tready = 1'b0;
  logic [31:0]   pkt_cnt, drop_cnt;
  logic          err;
  logic [2:0]    state;
  logic [2:0]    count;

  fsm_packet_assembler dut (
    .clk(clk), .rst_n(rst_n), .i_enable_dp(enable_dp), .i_rst_counters(rst_counters),
    .i_s_verdict_valid(v_valid), .o_s_verdict_ready(v_ready),
    .i_s_verdict_drop(v_drop), .i_s_verdict_short(v_short),
    .i_s_axis_hdr_tdata(hdr_tdata), .i_s_axis_hdr_tkeep(hdr_tkeep),
    .i_s_axis_hdr_tlast(hdr_tlast), .i_s_axis_hdr_tvalid(hdr_tvalid),
    .o_s_axis_hdr_tready(hdr_tready),
    .i_s_axis_pl_tdata(pl_tdata), .i_s_axis_pl_tkeep(pl_tkeep),
    .i_s_axis_pl_tlast(pl_tlast), .i_s_axis_pl_tvalid(pl_tvalid),
    .o_s_axis_pl_tready(pl_tready),
    .o_m_axis_tdata(m_tdata), .o_m_axis_tkeep(m_tkeep), .o_m_axis_tlast(m_tlast),
    .o_m_axis_tvalid(m_tvalid), .i_m_axis_tready(m_tready),
    .o_reg_pkt_counter(pkt_cnt), .o_reg_drop_counter(drop_cnt), .o_err_hdr_len(err),
    .o_state(state), .o_count(count)
  );

  typedef struct packed {logic [DW-1:0] d; logic [KW-1:0] k; logic l;} beat_t;
  typedef struct packed {logic drop; logic shrt;} verd_t;

  beat_t hdr_q[$], pl_q[$], exp_q[$], got_q[$];
  verd_t v_q[$];
  int    n_cmp = 0, n_err = 0, cyc = 0, clr_cyc = -1;
  int    v_cyc, first_m_cyc, hdr_beats, tl_cnt, exp_pkt = 0, exp_drop = 0;
  bit    rand_ready = 1'b0, seen_mv, seen_vr, seen_hr, seen_pr;
  logic [2:0]  snap_count, last_post_state;
  logic        snap_err;
  logic [31:0] clr_pkt, clr_drop;

  function automatic beat_t mk(input bit last);
    beat_t b;
    b.d = {$urandom(), $urandom()};
    b.k = KW'($urandom());
    b.l = last;
    return b;
  endfunction

  // Model: forwarded packets emit header (tlast only if short) then payload; drops emit nothing.
  task automatic push_pkt(input bit en, input bit drop, input bit shrt, input int nh, input int np);
    beat_t b;
    if (!en) begin
      for (int i = 0; i < np; i++) begin
        b = mk(i == np - 1); pl_q.push_back(b); exp_q.push_back(b);
      end
      exp_pkt++;
      return;
    end
    v_q.push_back('{drop: drop, shrt: shrt});
    for (int i = 0; i < nh; i++) begin
      b = mk(i == nh - 1); hdr_q.push_back(b);
      b.l = b.l & shrt;
      if (!drop) exp_q.push_back(b);
    end
    if (!shrt)
      for (int i = 0; i < np; i++) begin
        b = mk(i == np - 1); pl_q.push_back(b);
        if (!drop) exp_q.push_back(b);
      end
    if (drop) exp_drop++; else exp_pkt++;
  endtask

  task automatic clear_obs();
    seen_mv = 0; seen_vr = 0; seen_hr = 0; seen_pr = 0;
    got_q.delete(); exp_q.delete();
    first_m_cyc = -1; v_cyc = -1; hdr_beats = 0;
  endtask

  // One clock: drive queue heads at negedge, sample handshakes before posedge, retire after.
  task automatic step();
    bit hs_h, hs_p, hs_v, hs_m;
    beat_t mb;
    @(negedge clk);
    rst_counters = (cyc == clr_cyc);
    hdr_tvalid = hdr_q.size() > 0;
    if (hdr_tvalid) {hdr_tdata, hdr_tkeep, hdr_tlast} = hdr_q[0]; else hdr_tlast = 1'b0;
    pl_tvalid = pl_q.size() > 0;
    if (pl_tvalid) {pl_tdata, pl_tkeep, pl_tlast} = pl_q[0]; else pl_tlast = 1'b0;
    v_valid = v_q.size() > 0;
    if (v_valid) {v_drop, v_short} = v_q[0];
    m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    hs_h = hdr_tvalid & hdr_tready;
    hs_p = pl_tvalid & pl_tready;
    hs_v = v_valid & v_ready;
    hs_m = m_tvalid & m_tready;
    seen_mv |= m_tvalid; seen_vr |= v_ready; seen_hr |= hdr_tready; seen_pr |= pl_tready;
    mb = '{d: m_tdata, k: m_tkeep, l: m_tlast};
    @(posedge clk);
    #1;
    if (hs_v) begin v_cyc = cyc; hdr_beats = 0; void'(v_q.pop_front()); end
    if (hs_h) begin
      void'(hdr_q.pop_front());
      hdr_beats++;
      if (hdr_beats == 5) begin snap_count = count; snap_err = err; end
    end
    if (hs_p) void'(pl_q.pop_front());
    if (hs_m) begin
      if (got_q.size() == 0) first_m_cyc = cyc;
      got_q.push_back(mb);
      if (mb.l) last_post_state = state;
    end
    if (rst_counters) begin
      clr_pkt = pkt_cnt; clr_drop = drop_cnt; tl_cnt = 0;
    end else if (hs_m && mb.l) tl_cnt++;
    cyc++;
  endtask

  task automatic run(input int limit, input bit en, output bit ok);
    int n = 0;
    while (n < limit && !(got_q.size() >= exp_q.size() && pl_q.size() == 0 &&
                          (hdr_q.size() == 0 || !en))) begin
      step(); n++;
    end
    ok = (n < limit);
    repeat (2) step();
  endtask

  task automatic test_reset();
    enable_dp = 1'b1; v_valid = 1'b1; hdr_tvalid = 1'b1; pl_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({v_ready, hdr_tready, pl_tready, m_tvalid, m_tlast} !== 5'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b want 00000",
                        {v_ready, hdr_tready, pl_tready, m_tvalid, m_tlast});
    end
    v_valid = 1'b0; hdr_tvalid = 1'b0; pl_tvalid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({state, count, pkt_cnt, drop_cnt, err} !== '0) begin
      n_err++; $display("FAIL reset_state: state %0d count %0d pkt %0d drop %0d err %b want all 0",
                        state, count, pkt_cnt, drop_cnt, err);
    end
  endtask

  task automatic test_forward();
    bit ok;
    clear_obs(); rand_ready = 0;
    push_pkt(1, 0, 0, 5, 3);
    run(100, 1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL fwd_timeout: got timeout want done"); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL fwd_len: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL fwd_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (first_m_cyc != v_cyc + 1) begin
      n_err++; $display("FAIL fwd_latency: got cyc %0d want %0d", first_m_cyc, v_cyc + 1);
    end
    n_cmp++;
    if (pkt_cnt !== 32'(exp_pkt)) begin
      n_err++; $display("FAIL fwd_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt);
    end
  endtask

  task automatic test_short();
    bit ok;
    clear_obs(); rand_ready = 0;
    push_pkt(1, 0, 1, 2, 0);
    run(100, 1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL short_timeout: got timeout want done"); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL short_len: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL short_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (seen_pr) begin n_err++; $display("FAIL short_pl_tready: got 1 want 0"); end
    n_cmp++;
    if (last_post_state !== 3'd0) begin
      n_err++; $display("FAIL short_idle_after: got %0d want 0", last_post_state);
    end
    n_cmp++;
    if (pkt_cnt !== 32'(exp_pkt)) begin
      n_err++; $display("FAIL short_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt);
    end
  endtask

  task automatic test_drop();
    bit ok;
    clear_obs(); rand_ready = 0;
    push_pkt(1, 1, 0, 5, 4);
    run(100, 1, ok);
    n_cmp++;
    if (!ok || hdr_q.size() != 0 || pl_q.size() != 0) begin
      n_err++; $display("FAIL drop_consume: got hdr %0d pl %0d left want 0 0",
                        hdr_q.size(), pl_q.size());
    end
    n_cmp++; if (seen_mv) begin n_err++; $display("FAIL drop_m_tvalid: got 1 want 0"); end
    n_cmp++;
    if (drop_cnt !== 32'(exp_drop) || pkt_cnt !== 32'(exp_pkt)) begin
      n_err++; $display("FAIL drop_counters: got drop %0d pkt %0d want %0d %0d",
                        drop_cnt, pkt_cnt, exp_drop, exp_pkt);
    end
  endtask

  task automatic test_bypass();
    bit ok;
    clear_obs(); rand_ready = 0;
    enable_dp = 1'b0;
    push_pkt(0, 0, 0, 0, 6);
    v_q.push_back('{drop: 1'b0, shrt: 1'b0});
    hdr_q.push_back(mk(1'b1));
    run(100, 0, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL byp_timeout: got timeout want done"); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL byp_len: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL byp_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (seen_vr || seen_hr) begin
      n_err++; $display("FAIL byp_hdr_side: got vready %b hready %b want 0 0", seen_vr, seen_hr);
    end
    n_cmp++;
    if (pkt_cnt !== 32'(exp_pkt)) begin
      n_err++; $display("FAIL byp_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt);
    end
    v_q.delete(); hdr_q.delete();
    enable_dp = 1'b1;
  endtask

  task automatic test_random();
    bit ok;
    int nerr_beats = 0;
    clear_obs(); rand_ready = 1;
    clr_pkt = 32'hdead_beef; clr_drop = 32'hdead_beef;
    for (int p = 0; p < 100; p++)
      push_pkt(1, 0, ($urandom_range(0, 3) == 0), $urandom_range(1, 5), $urandom_range(1, 4));
    clr_cyc = cyc + 200;
    run(5000, 1, ok);
    clr_cyc = -1;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rnd_timeout: got timeout want done"); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rnd_len: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i] && nerr_beats < 10) begin
        nerr_beats++; n_err++;
        $display("FAIL rnd_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end else if (got_q[i] !== exp_q[i]) n_err++;
    end
    n_cmp++;
    if (clr_pkt !== 32'd0 || clr_drop !== 32'd0) begin
      n_err++; $display("FAIL rnd_clear: got pkt %0d drop %0d want 0 0", clr_pkt, clr_drop);
    end
    exp_pkt = tl_cnt; exp_drop = 0;
    n_cmp++;
    if (pkt_cnt !== 32'(exp_pkt) || drop_cnt !== 32'(exp_drop)) begin
      n_err++; $display("FAIL rnd_counters: got pkt %0d drop %0d want %0d %0d",
                        pkt_cnt, drop_cnt, exp_pkt, exp_drop);
    end
    rand_ready = 0;
  endtask

  task automatic test_overflow_reset();
    bit ok;
    int n = 0;
    clear_obs(); snap_count = 'x; snap_err = 1'bx;
    push_pkt(1, 0, 0, 6, 3);
    run(100, 1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ovf_timeout: got timeout want done"); end
    n_cmp++;
    if (snap_count !== 3'd4 || snap_err !== 1'b1) begin
      n_err++; $display("FAIL ovf_beat5: got count %0d err %b want 4 1", snap_count, snap_err);
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL ovf_len: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL ovf_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", err); end
    clr_cyc = cyc;
    step();
    clr_cyc = -1;
    n_cmp++;
    if (err !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", err); end

    clear_obs();
    push_pkt(1, 0, 0, 2, 5);
    while (got_q.size() < 3 && n < 50) begin step(); n++; end
    n_cmp++;
    if (state !== 3'd2) begin n_err++; $display("FAIL rst_mid_pre: got state %0d want 2", state); end
    @(negedge clk); rst_n = 1'b0; #1;
    n_cmp++;
    if ({state, count, v_ready, hdr_tready, pl_tready, m_tvalid, m_tlast} !== '0) begin
      n_err++; $display("FAIL rst_mid: state %0d count %0d rdy %b%b%b mv %b ml %b want all 0",
                        state, count, v_ready, hdr_tready, pl_tready, m_tvalid, m_tlast);
    end
    n_cmp++;
    if (pkt_cnt !== 32'd0 || drop_cnt !== 32'd0) begin
      n_err++; $display("FAIL rst_mid_cnt: got pkt %0d drop %0d want 0 0", pkt_cnt, drop_cnt);
    end
    hdr_q.delete(); pl_q.delete(); v_q.delete();
    hdr_tvalid = 1'b0; pl_tvalid = 1'b0; v_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (state !== 3'd0) begin n_err++; $display("FAIL rst_release: got %0d want 0", state); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_short();
    test_drop();
    test_bypass();
    test_random();
    test_overflow_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
